// File: rtl/move_checker.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// move_checker : sequential left/right/down/rotate legality check over board RAM
// Rev 1.0
// =============================================================================
module move_checker #(
  parameter int BOARD_W   = 16,
  parameter int BOARD_H   = 20,
  parameter int CELL_BITS = 3,
  parameter int XW        = 4,
  parameter int YW        = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [1:0]           i_dir,
  input  logic [2:0]           i_piece_type,
  input  logic [1:0]           i_rotation,
  input  logic [XW-1:0]        i_xpos,
  input  logic [YW-1:0]        i_ypos,
  output logic                 o_rd_en,
  output logic [XW-1:0]        o_rd_x,
  output logic [YW-1:0]        o_rd_y,
  input  logic [CELL_BITS-1:0] i_rd_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_can_move,
  output logic [XW-1:0]        o_new_x,
  output logic [YW-1:0]        o_new_y,
  output logic [1:0]           o_new_rot
);

  localparam logic [XW+1:0] c_board_w = (XW+2)'(BOARD_W);
  localparam logic [YW+1:0] c_board_h = (YW+2)'(BOARD_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [2:0]    r_type;
  logic [1:0]    r_dir;
  logic [1:0]    r_rot;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [1:0]    r_idx;

  logic [2:0]    w_type;
  logic [1:0]    w_dir;
  logic [1:0]    w_rot;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [1:0]    w_idx;
  logic [1:0]    w_trot;
  logic [XW+1:0] w_tx;
  logic [YW+1:0] w_ty;
  logic [15:0]   w_shape;
  logic [3:0]    w_cell;
  logic [1:0]    w_nm;
  logic [1:0]    w_dx;
  logic [1:0]    w_dy;
  logic [XW+1:0] w_col;
  logic [YW+1:0] w_row;
  logic          w_oob;

  // One cell generator serves both the first cell (from live inputs) and
  // every following cell (from the latched request), so the read address is
  // always ready one cycle ahead and RdEn/RdX/RdY can be registered.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_type = i_piece_type;
      w_dir  = i_dir;
      w_rot  = i_rotation;
      w_x    = i_xpos;
      w_y    = i_ypos;
      w_idx  = 2'd0;
    end else begin
      w_type = r_type;
      w_dir  = r_dir;
      w_rot  = r_rot;
      w_x    = r_x;
      w_y    = r_y;
      w_idx  = r_idx + 2'd1;
    end
  end

  always_comb begin
    w_tx   = {2'b00, w_x};
    w_ty   = {2'b00, w_y};
    w_trot = w_rot;
    case (w_dir)
      2'd0:    w_tx   = {2'b00, w_x} - (XW+2)'(1);
      2'd1:    w_tx   = {2'b00, w_x} + (XW+2)'(1);
      2'd2:    w_ty   = {2'b00, w_y} + (YW+2)'(1);
      default: w_trot = w_rot + 2'd1;
    endcase
  end

  // Rotation-0 cells packed as {x3,y3,x2,y2,x1,y1,x0,y0}; w_nm is box size - 1.
  always_comb begin
    w_nm    = 2'd2;
    w_shape = 16'h0000;
    case (w_type)
      3'd0: begin
        w_nm    = 2'd3;
        w_shape = {2'd3, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
      end
      3'd1: begin
        w_nm    = 2'd1;
        w_shape = {2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
      end
      3'd2:    w_shape = {2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
      3'd3:    w_shape = {2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
      3'd4:    w_shape = {2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
      3'd5:    w_shape = {2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0};
      3'd6:    w_shape = {2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
      default: w_shape = 16'h0000;
    endcase
  end

  assign w_cell = w_shape[{w_idx, 2'b00} +: 4];

  always_comb begin
    case (w_trot)
      2'd0: begin w_dx = w_cell[3:2];        w_dy = w_cell[1:0];        end
      2'd1: begin w_dx = w_nm - w_cell[1:0]; w_dy = w_cell[3:2];        end
      2'd2: begin w_dx = w_nm - w_cell[3:2]; w_dy = w_nm - w_cell[1:0]; end
      default: begin w_dx = w_cell[1:0];     w_dy = w_nm - w_cell[3:2]; end
    endcase
  end

  assign w_col = w_tx + {{XW{1'b0}}, w_dx};
  assign w_row = w_ty + {{YW{1'b0}}, w_dy};
  // A negative column wraps to a large unsigned value, so one compare covers both edges.
  assign w_oob = (w_type == 3'd7) || (w_col >= c_board_w) || (w_row >= c_board_h);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_type     <= 3'd0;
      r_dir      <= 2'd0;
      r_rot      <= 2'd0;
      r_x        <= '0;
      r_y        <= '0;
      r_idx      <= 2'd0;
      o_rd_en    <= 1'b0;
      o_rd_x     <= '0;
      o_rd_y     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_can_move <= 1'b0;
      o_new_x    <= '0;
      o_new_y    <= '0;
      o_new_rot  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_type  <= i_piece_type;
            r_dir   <= i_dir;
            r_rot   <= i_rotation;
            r_x     <= i_xpos;
            r_y     <= i_ypos;
            r_idx   <= 2'd0;
            o_busy  <= 1'b1;
            o_rd_en <= !w_oob;
            if (!w_oob) begin
              o_rd_x <= w_col[XW-1:0];
              o_rd_y <= w_row[YW-1:0];
            end
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_rd_en <= 1'b0;
          if (o_rd_en) begin
            r_state <= S_EVAL;
          end else begin
            o_can_move <= 1'b0;
            o_new_x    <= r_x;
            o_new_y    <= r_y;
            o_new_rot  <= r_rot;
            o_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_EVAL: begin
          if (i_rd_data != '0) begin
            o_can_move <= 1'b0;
            o_new_x    <= r_x;
            o_new_y    <= r_y;
            o_new_rot  <= r_rot;
            o_done     <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_idx == 2'd3) begin
            o_can_move <= 1'b1;
            o_new_x    <= w_tx[XW-1:0];
            o_new_y    <= w_ty[YW-1:0];
            o_new_rot  <= w_trot;
            o_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_idx   <= r_idx + 2'd1;
            o_rd_en <= !w_oob;
            if (!w_oob) begin
              o_rd_x <= w_col[XW-1:0];
              o_rd_y <= w_row[YW-1:0];
            end
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_move_checker.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_move_checker : randomized self-checking bench with a cell-list reference model
// Rev 1.0
// =============================================================================
module tb_move_checker;

  localparam int W = 16;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_dir = 2'd0;
  logic [2:0] i_piece_type = 3'd0;
  logic [1:0] i_rotation = 2'd0;
  logic [3:0] i_xpos = 4'd0;
  logic [4:0] i_ypos = 5'd0;
  logic       o_rd_en;
  logic [3:0] o_rd_x;
  logic [4:0] o_rd_y;
  logic [2:0] i_rd_data = 3'd0;
  logic       o_busy, o_done, o_can_move;
  logic [3:0] o_new_x;
  logic [4:0] o_new_y;
  logic [1:0] o_new_rot;

  move_checker #(.BOARD_W(W), .BOARD_H(H), .CELL_BITS(3), .XW(4), .YW(5)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_dir(i_dir),
    .i_piece_type(i_piece_type), .i_rotation(i_rotation),
    .i_xpos(i_xpos), .i_ypos(i_ypos),
    .o_rd_en(o_rd_en), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .i_rd_data(i_rd_data),
    .o_busy(o_busy), .o_done(o_done), .o_can_move(o_can_move),
    .o_new_x(o_new_x), .o_new_y(o_new_y), .o_new_rot(o_new_rot)
  );

  always #5 clk = ~clk;

  int board[W][H];

  // Synchronous-read board RAM
  always @(posedge clk) begin
    if (o_rd_en && int'(o_rd_y) < H) i_rd_data <= 3'(board[int'(o_rd_x)][int'(o_rd_y)]);
  end

  int n_tests = 0;
  int n_fail  = 0;

  int sx[7][4] = '{'{0,1,2,3}, '{0,1,0,1}, '{1,0,1,2}, '{1,2,0,1}, '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
  int sy[7][4] = '{'{1,1,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};
  int nsz[7]   = '{4, 2, 3, 3, 3, 3, 3};

  int exp_done, exp_can, exp_nx, exp_ny, exp_nr;
  int exp_rd[$];
  int prev_can = 0, prev_nx = 0, prev_ny = 0, prev_nr = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk the piece's cells in order, rotating each one step at a time.
  task automatic model(input int t, input int dir, input int rot, input int x, input int y);
    int tx, ty, tr, cx, cy, nx, col, row;
    tx = x; ty = y; tr = rot;
    exp_rd.delete();
    if (dir == 0) tx = x - 1;
    else if (dir == 1) tx = x + 1;
    else if (dir == 2) ty = y + 1;
    else tr = (rot + 1) % 4;
    exp_can = 0; exp_nx = x; exp_ny = y; exp_nr = rot;
    if (t == 7) begin
      exp_done = 2;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      cx = sx[t][i];
      cy = sy[t][i];
      for (int k = 0; k < tr; k++) begin
        nx = nsz[t] - 1 - cy;
        cy = cx;
        cx = nx;
      end
      col = tx + cx;
      row = ty + cy;
      if (col < 0 || col >= W || row >= H) begin
        exp_done = 2 * i + 2;
        return;
      end
      exp_rd.push_back(col * 32 + row);
      if (board[col][row] != 0) begin
        exp_done = 2 * i + 3;
        return;
      end
    end
    exp_done = 9;
    exp_can  = 1;
    exp_nx   = tx & 15;
    exp_ny   = ty & 31;
    exp_nr   = tr;
  endtask

  task automatic clear_board();
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++) board[c][r] = 0;
  endtask

  task automatic random_board(input int density);
    for (int c = 0; c < W; c++)
      for (int r = 0; r < H; r++)
        board[c][r] = ($urandom_range(0, 99) < density) ? int'($urandom_range(1, 7)) : 0;
  endtask

  // Entered at the falling edge of an idle cycle; returns at the falling edge after Done.
  task automatic run_req(input int t, input int dir, input int rot, input int x, input int y,
                         input bit hold);
    int done_cyc;
    bit busy_ok;
    int got_rd[$];
    check("held_can_move", int'(o_can_move), prev_can);
    check("held_new_pos", int'(o_new_x) * 1024 + int'(o_new_y) * 4 + int'(o_new_rot),
          prev_nx * 1024 + prev_ny * 4 + prev_nr);
    model(t, dir, rot, x, y);
    i_piece_type = 3'(t);
    i_dir        = 2'(dir);
    i_rotation   = 2'(rot);
    i_xpos       = 4'(x);
    i_ypos       = 5'(y);
    i_start      = 1'b1;
    @(negedge clk);
    if (!hold) i_start = 1'b0;
    done_cyc = 0;
    busy_ok  = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (!o_busy) busy_ok = 1'b0;
      if (o_rd_en) got_rd.push_back(int'(o_rd_x) * 32 + int'(o_rd_y));
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    check("done_cycle", done_cyc, exp_done);
    check("busy_during", int'(busy_ok), 1);
    check("can_move", int'(o_can_move), exp_can);
    check("new_x", int'(o_new_x), exp_nx);
    check("new_y", int'(o_new_y), exp_ny);
    check("new_rot", int'(o_new_rot), exp_nr);
    check("read_count", got_rd.size(), exp_rd.size());
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      check("read_xy", got_rd[i], exp_rd[i]);
    prev_can = exp_can; prev_nx = exp_nx; prev_ny = exp_ny; prev_nr = exp_nr;
    @(negedge clk);
    check("done_one_cycle", int'(o_done), 0);
    check("busy_clear", int'(o_busy), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_done"}, int'(o_done), 0);
    check({tag, "_rd_en"}, int'(o_rd_en), 0);
    check({tag, "_rd_xy"}, int'(o_rd_x) * 32 + int'(o_rd_y), 0);
    check({tag, "_can_move"}, int'(o_can_move), 0);
    check({tag, "_new"}, int'(o_new_x) * 1024 + int'(o_new_y) * 4 + int'(o_new_rot), 0);
  endtask

  initial begin
    int t, r;
    bit saw_done;
    clear_board();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the edge conditions of the move rules
    run_req(0, 1, 0, 12, 0, 1'b0);
    run_req(1, 0, 0, 0, 0, 1'b0);
    run_req(2, 2, 0, 5, 10, 1'b0);
    board[5][12] = 5;
    run_req(2, 2, 0, 5, 10, 1'b0);
    clear_board();
    run_req(0, 3, 0, 3, 18, 1'b0);
    run_req(5, 3, 3, 5, 0, 1'b0);
    run_req(7, 1, 0, 4, 4, 1'b0);

    // Start held through the whole request: only one request may be served
    run_req(2, 2, 0, 5, 10, 1'b1);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (o_busy || o_done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("held_start_single", int'(saw_done), 0);

    // Reset in cycle 4 of a passing request
    i_piece_type = 3'd2; i_dir = 2'd2; i_rotation = 2'd0; i_xpos = 4'd5; i_ypos = 5'd10;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    saw_done = 1'b0;
    for (int cyc = 1; cyc < 4; cyc++) begin
      if (o_done) saw_done = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_done", int'(saw_done | o_done), 0);
    check_reset_values("abort");
    rst = 1'b0;
    prev_can = 0; prev_nx = 0; prev_ny = 0; prev_nr = 0;
    @(negedge clk);

    // Randomized requests on randomized boards
    for (int n = 0; n < 300; n++) begin
      if (n % 25 == 0) random_board(int'($urandom_range(0, 30)));
      t = ($urandom_range(0, 19) == 0) ? 7 : int'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 0) begin
        r = int'($urandom_range(0, 4));
        r = (r < 2) ? r : r + 11;
      end else begin
        r = int'($urandom_range(0, 15));
      end
      run_req(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r,
              int'($urandom_range(0, 19)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
